// File: rtl/param_queue.sv
// Parametrised circular-buffer queue for event/spike words, with registered or
// first-word-fall-through read, occupancy status and sticky error flags.
module param_queue #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int FWFT         = 0,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     insert,
    input  logic                     read,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic full, empty;
    logic rd_acc, wr_acc, wr_en;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign rd_acc = read && !empty;
    // A full queue still takes a word when the head leaves on the same edge.
    assign wr_acc = insert && (!full || rd_acc);
    assign wr_en  = wr_acc && !clear_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc)
                rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_acc && !rd_acc)
                count_d = count_q + CW'(1);
            else if (rd_acc && !wr_acc)
                count_d = count_q - CW'(1);
            if (insert && !wr_acc)
                overflow_d = 1'b1;
            if (read && empty)
                underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is left unreset so it maps onto RAM; reset is gated out of the write.
    always_ff @(posedge clk) begin
        if (rst && wr_en)
            mem_q[wr_ptr_q] <= data_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign valid_o = !empty;
            assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q, rdata_d;
            logic             rvalid_q, rvalid_d;

            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = 1'b0;
                if (clear_i) begin
                    rdata_d = '0;
                end else if (rd_acc) begin
                    rdata_d  = mem_q[rd_ptr_q];
                    rvalid_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign valid_o = rvalid_q;
            assign data_o  = rdata_q;
        end
    endgenerate

    assign full_o        = full;
    assign empty_o       = empty;
    assign almost_full_o = (count_q >= CW'(AFULL_THRESH));
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_param_queue.sv
// Directed checks for param_queue: a registered-read instance (a) and a
// first-word-fall-through instance (b), both DEPTH=4, WIDTH=8, AFULL_THRESH=3.
module tb_param_queue;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       clr_a, ins_a, rd_a;
    logic [7:0] din_a;
    logic       valid_a, full_a, empty_a, afull_a, ovf_a, udf_a;
    logic [7:0] dout_a;
    logic [2:0] cnt_a;

    logic       clr_b, ins_b, rd_b;
    logic [7:0] din_b;
    logic       valid_b, full_b, empty_b, afull_b, ovf_b, udf_b;
    logic [7:0] dout_b;
    logic [2:0] cnt_b;

    int n_chk  = 0;
    int n_fail = 0;

    param_queue #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AFULL_THRESH(3)) u_reg (
        .clk(clk), .rst(rst), .clear_i(clr_a), .insert(ins_a), .read(rd_a),
        .data_i(din_a), .valid_o(valid_a), .data_o(dout_a), .full_o(full_a),
        .empty_o(empty_a), .almost_full_o(afull_a), .count_o(cnt_a),
        .overflow_o(ovf_a), .underflow_o(udf_a)
    );

    param_queue #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AFULL_THRESH(3)) u_fwft (
        .clk(clk), .rst(rst), .clear_i(clr_b), .insert(ins_b), .read(rd_b),
        .data_i(din_b), .valid_o(valid_b), .data_o(dout_b), .full_o(full_b),
        .empty_o(empty_b), .almost_full_o(afull_b), .count_o(cnt_b),
        .overflow_o(ovf_b), .underflow_o(udf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One edge with given (insert, data, read) on the registered instance.
    task automatic step_a(input logic ins, input logic [7:0] d, input logic rd);
        ins_a = ins;
        din_a = d;
        rd_a  = rd;
        tick();
        ins_a = 1'b0;
        rd_a  = 1'b0;
        $display("step a: ins=%0b d=%02h rd=%0b -> valid=%0b data=%02h count=%0d ovf=%0b udf=%0b",
                 ins, d, rd, valid_a, dout_a, cnt_a, ovf_a, udf_a);
    endtask

    task automatic step_b(input logic ins, input logic [7:0] d, input logic rd);
        ins_b = ins;
        din_b = d;
        rd_b  = rd;
        tick();
        ins_b = 1'b0;
        rd_b  = 1'b0;
        $display("step b: ins=%0b d=%02h rd=%0b -> valid=%0b data=%02h count=%0d",
                 ins, d, rd, valid_b, dout_b, cnt_b);
    endtask

    initial begin
        rst = 1'b0;
        clr_a = 0; ins_a = 0; rd_a = 0; din_a = 8'h00;
        clr_b = 0; ins_b = 0; rd_b = 0; din_b = 8'h00;
        tick();
        chk("rst_count", cnt_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_afull", afull_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_data", dout_a, 8'h00);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_udf", udf_a, 0);
        chk("rst_b_valid", valid_b, 0);
        chk("rst_b_data", dout_b, 8'h00);
        rst = 1'b1;

        // Basic registered-mode order
        step_a(1, 8'h01, 0); chk("t1_cnt1", cnt_a, 1);
        step_a(1, 8'h02, 0); chk("t1_cnt2", cnt_a, 2); chk("t1_afull_lo", afull_a, 0);
        step_a(1, 8'h03, 0); chk("t1_cnt3", cnt_a, 3); chk("t1_afull_hi", afull_a, 1);
        chk("t1_valid_pre", valid_a, 0);
        step_a(0, 8'h00, 1); chk("t1_v1", valid_a, 1); chk("t1_d1", dout_a, 8'h01);
        chk("t1_cnt_r1", cnt_a, 2); chk("t1_afull_fall", afull_a, 0);
        step_a(0, 8'h00, 1); chk("t1_v2", valid_a, 1); chk("t1_d2", dout_a, 8'h02);
        step_a(0, 8'h00, 1); chk("t1_v3", valid_a, 1); chk("t1_d3", dout_a, 8'h03);
        chk("t1_cnt0", cnt_a, 0); chk("t1_empty", empty_a, 1);
        step_a(0, 8'h00, 0); chk("t1_vlow", valid_a, 0); chk("t1_hold", dout_a, 8'h03);

        // Fill, overflow, pointer wrap
        step_a(1, 8'hA0, 0);
        step_a(1, 8'hA1, 0);
        step_a(1, 8'hA2, 0); chk("t2_notfull", full_a, 0);
        step_a(1, 8'hA3, 0); chk("t2_full", full_a, 1); chk("t2_cnt4", cnt_a, 4);
        chk("t2_noovf", ovf_a, 0);
        step_a(1, 8'hA4, 0); chk("t2_ovf", ovf_a, 1); chk("t2_cnt_drop", cnt_a, 4);
        step_a(0, 8'h00, 1); chk("t2_dA0", dout_a, 8'hA0);
        step_a(0, 8'h00, 1); chk("t2_dA1", dout_a, 8'hA1); chk("t2_cnt2", cnt_a, 2);
        step_a(1, 8'hB0, 0);
        step_a(1, 8'hB1, 0); chk("t2_full2", full_a, 1);
        step_a(0, 8'h00, 1); chk("t2_dA2", dout_a, 8'hA2);
        step_a(0, 8'h00, 1); chk("t2_dA3", dout_a, 8'hA3);
        step_a(0, 8'h00, 1); chk("t2_dB0", dout_a, 8'hB0);
        step_a(0, 8'h00, 1); chk("t2_dB1", dout_a, 8'hB1);
        chk("t2_empty", empty_a, 1); chk("t2_ovf_sticky", ovf_a, 1);

        // Clear drops the sticky flag
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        $display("clear a -> count=%0d ovf=%0b", cnt_a, ovf_a);
        chk("clr1_ovf", ovf_a, 0); chk("clr1_empty", empty_a, 1);

        // Simultaneous insert+read on a full queue
        step_a(1, 8'hC0, 0);
        step_a(1, 8'hC1, 0);
        step_a(1, 8'hC2, 0);
        step_a(1, 8'hC3, 0); chk("t3_full", full_a, 1);
        step_a(1, 8'hC4, 1); chk("t3_cnt", cnt_a, 4); chk("t3_noovf", ovf_a, 0);
        chk("t3_head", dout_a, 8'hC0); chk("t3_valid", valid_a, 1);
        step_a(0, 8'h00, 1); chk("t3_dC1", dout_a, 8'hC1);
        step_a(0, 8'h00, 1); chk("t3_dC2", dout_a, 8'hC2);
        step_a(0, 8'h00, 1); chk("t3_dC3", dout_a, 8'hC3);
        step_a(0, 8'h00, 1); chk("t3_dC4", dout_a, 8'hC4); chk("t3_empty", empty_a, 1);

        // Simultaneous insert+read on an empty queue: no bypass
        step_a(1, 8'hD0, 1); chk("t4_cnt1", cnt_a, 1); chk("t4_udf", udf_a, 1);
        chk("t4_novalid", valid_a, 0);

        // Build 3 words with both flags set, then clear with insert
        step_a(1, 8'hD1, 0);
        step_a(1, 8'hD2, 0);
        step_a(1, 8'hD3, 0);
        step_a(1, 8'hD4, 0); chk("t5_ovf", ovf_a, 1);
        step_a(0, 8'h00, 1); chk("t5_dD0", dout_a, 8'hD0); chk("t5_cnt3", cnt_a, 3);
        clr_a = 1'b1; ins_a = 1'b1; din_a = 8'hEE; tick();
        clr_a = 1'b0; ins_a = 1'b0;
        $display("clear+insert a -> count=%0d empty=%0b ovf=%0b udf=%0b", cnt_a, empty_a, ovf_a, udf_a);
        chk("t5_cnt0", cnt_a, 0); chk("t5_empty", empty_a, 1);
        chk("t5_ovf0", ovf_a, 0); chk("t5_udf0", udf_a, 0); chk("t5_valid0", valid_a, 0);

        // Same again, but ended with reset
        step_a(0, 8'h00, 1); chk("t6_udf", udf_a, 1);
        step_a(1, 8'hE0, 0);
        step_a(1, 8'hE1, 0);
        step_a(1, 8'hE2, 0);
        step_a(1, 8'hE3, 0);
        step_a(1, 8'hE4, 0); chk("t6_ovf", ovf_a, 1);
        step_a(0, 8'h00, 1); chk("t6_dE0", dout_a, 8'hE0); chk("t6_cnt3", cnt_a, 3);
        rst = 1'b0; ins_a = 1'b1; din_a = 8'hEE; tick();
        rst = 1'b1; ins_a = 1'b0;
        $display("reset+insert a -> count=%0d valid=%0b data=%02h", cnt_a, valid_a, dout_a);
        chk("t6_cnt0", cnt_a, 0); chk("t6_empty", empty_a, 1);
        chk("t6_ovf0", ovf_a, 0); chk("t6_udf0", udf_a, 0);
        chk("t6_data0", dout_a, 8'h00); chk("t6_valid0", valid_a, 0);

        // First-word-fall-through instance
        chk("f_idle_valid", valid_b, 0);
        step_b(1, 8'h5A, 0); chk("f_valid", valid_b, 1); chk("f_d5A", dout_b, 8'h5A);
        step_b(1, 8'h5B, 0); chk("f_cnt2", cnt_b, 2); chk("f_head", dout_b, 8'h5A);
        step_b(0, 8'h00, 1); chk("f_d5B", dout_b, 8'h5B); chk("f_valid2", valid_b, 1);
        step_b(0, 8'h00, 1); chk("f_valid_end", valid_b, 0); chk("f_empty", empty_b, 1);
        chk("f_noudf", udf_b, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/param_queue.md
Name: param_queue

Overview:
- Parametrised successor to the single-channel 8-bit `queue`, used to buffer event/spike words between producer and consumer stages of the accelerator datapath.
- Adds:
  - configurable width and depth;
  - selectable read mode (registered vs first-word-fall-through);
  - full, empty, occupancy and almost-full status;
  - sticky overflow/underflow error flags;
  - synchronous flush.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- FWFT, 0, 0 = registered read (data one cycle after read); 1 = first-word-fall-through (head always presented).
- AFULL_THRESH, DEPTH-1, almost_full_o asserts when count >= this value (1..DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising edge of clk)
- clear_i  in  1  synchronous flush: empties queue and clears error flags
- insert  in  1  write request; data_i captured on the same edge
- read  in  1  read/pop request
- data_i  in  WIDTH  write data
- valid_o  out  1  data_o holds valid data (meaning is per mode, see Behaviour)
- data_o  out  WIDTH  read data
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- almost_full_o  out  1  count >= AFULL_THRESH
- count_o  out  $clog2(DEPTH)+1  current occupancy
- overflow_o  out  1  sticky: an insert was dropped
- underflow_o  out  1  sticky: a read occurred while empty

Behaviour:
- Reset (rst==0 at edge):
  - pointers, count_o, data_o, valid_o, overflow_o and underflow_o all go to 0.
  - empty_o=1, full_o=0, almost_full_o=0.
  - Reset overrides all other inputs.
- clear_i (rst==1):
  - Same result as reset, on the next edge.
  - Overrides insert and read in the same cycle.
- Storage and pointers:
  - Circular buffer of DEPTH entries.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count_o is tracked explicitly.
- Insert:
  - Accepted if not full, or if full and a read is also accepted in the same cycle.
  - An accepted insert writes data_i at wr_ptr and increments wr_ptr.
  - An insert that is not accepted is dropped: memory and pointers are unchanged and overflow_o is set.
- Read:
  - Accepted if not empty; increments rd_ptr.
  - A read while empty is ignored and sets underflow_o, even if an insert happens in the same cycle (no bypass).
- Count update:
  - +1 for an accepted insert only.
  - -1 for an accepted read only.
  - Unchanged when both are accepted.
- Status timing: full_o, empty_o and almost_full_o derive from the registered count_o and are valid in the cycle after the change.
- FWFT=0 (registered) mode:
  - On an accepted read, data_o <= mem[rd_ptr] and valid_o <= 1 on that edge, so data is visible one cycle after read is sampled.
  - valid_o is a one-cycle pulse per accepted read. Back-to-back reads give back-to-back valid cycles.
  - When valid_o==0, data_o holds its last value.
- FWFT=1 (fall-through) mode:
  - valid_o = !empty_o.
  - data_o = mem[rd_ptr], combinational from registered state.
  - read acts as a pop acknowledge; the next word appears in the cycle after the pop.
  - A word inserted into an empty queue appears on data_o one cycle after the insert edge.
- Sticky flags:
  - overflow_o and underflow_o stay set until rst or clear_i.
  - They never affect data flow.
- X-handling: insert and read are treated as 0 during reset.

Test Plan:
- Registered mode basic order (FWFT=0, DEPTH=4, WIDTH=8):
  - Stimulus: rst=0 for 1 cycle; insert 0x01, 0x02, 0x03 on consecutive cycles; then read 3 cycles.
  - Response: valid_o pulses 3 cycles; data_o = 0x01, 0x02, 0x03, each one cycle after its read; count_o steps 3->0; empty_o=1 at end.
- Full, overflow and wrap:
  - Stimulus: insert 0xA0..0xA4 (5 words).
  - Response: full_o=1 after the 4th insert; 0xA4 dropped; overflow_o=1.
  - Then read 2, insert 0xB0 and 0xB1 (pointer wrap), read 4.
  - Response: data_o = 0xA0, 0xA1, then 0xA2, 0xA3, 0xB0, 0xB1; overflow_o still 1 until clear_i.
- Simultaneous events:
  - Full queue, insert+read same cycle: count_o stays 4, no overflow, head popped, new word stored.
  - Empty queue, insert+read same cycle: count_o becomes 1, underflow_o=1, valid_o stays 0 (FWFT=0).
- FWFT mode (FWFT=1):
  - Insert 0x5A into an empty queue: valid_o=1 and data_o=0x5A one cycle after the insert edge.
  - Insert 0x5B, then pulse read once: data_o=0x5B on the following cycle.
  - Final read: valid_o=0.
- Almost-full (AFULL_THRESH=3): almost_full_o rises when count_o reaches 3 and falls when it returns to 2.
- Flush/reset mid-operation:
  - Stimulus: queue holds 3 words with both flags set; assert clear_i together with insert=1.
  - Response next cycle: count_o=0, empty_o=1, flags=0, insert ignored.
  - Repeat with rst=0: same result plus data_o=0 and valid_o=0.
